// File: rtl/or1200_wbmux_nch.sv
// or1200_wbmux_nch: N-source write-back mux; the top channel is an accelerator behind a result FIFO with a stall request.
// Optional OR1200_WBMUX_STALLCNT_EN adds a saturating accelerator stall-cycle counter on acc_stall_cnt.
module or1200_wbmux_nch #(
    parameter int DW        = 32,
    parameter int NSRC      = 8,
    parameter int OPW       = 4,
    parameter int ACC_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_freeze,
    input  logic [OPW-1:0]     rfwb_op,
    input  logic [NSRC*DW-1:0] muxin,
    input  logic               acc_valid,
    input  logic [DW-1:0]      acc_data,
    output logic               acc_ready,
    output logic               acc_stall,
    output logic [DW-1:0]      muxout,
    output logic [DW-1:0]      muxreg,
    output logic               muxreg_valid,
    output logic [15:0]        acc_stall_cnt
);
    localparam int SW      = OPW - 1;
    localparam int ACC_SEL = NSRC - 1;
    localparam int AW      = ACC_DEPTH > 1 ? $clog2(ACC_DEPTH) : 1;

    logic [SW-1:0] w_sel;
    logic          w_we, w_acc_sel, w_empty, w_full, w_consume, w_push, w_pop, w_unused;
    logic [DW-1:0] w_head, w_chan;

    assign w_sel     = rfwb_op[OPW-1:1];
    assign w_we      = rfwb_op[0];
    assign w_acc_sel = w_sel == SW'(ACC_SEL);
    assign w_unused  = ^muxin[ACC_SEL*DW +: DW];

    assign acc_ready = !w_full;
    assign acc_stall = w_we & w_acc_sel & w_empty & !acc_valid;
    assign w_consume = !wb_freeze & w_we & w_acc_sel & !acc_stall;
    // a result consumed straight from acc_data bypasses the empty FIFO
    assign w_push    = acc_valid & acc_ready & !(w_empty & w_consume);
    assign w_pop     = w_consume & !w_empty;

    always_comb begin
        w_chan = '0;
        for (int i = 0; i < ACC_SEL; i++)
            if (w_sel == SW'(i)) w_chan = muxin[i*DW +: DW];
    end

    assign muxout = w_acc_sel ? (!w_empty ? w_head : acc_valid ? acc_data : '0) : w_chan;

    generate
        if (ACC_DEPTH == 1) begin : g_one
            logic          r_vld;
            logic [DW-1:0] r_data;
            always_ff @(posedge clk or posedge rst)
                if (rst) r_vld <= 1'b0;
                else if (w_push | w_pop) r_vld <= w_push;
            always_ff @(posedge clk)
                if (w_push) r_data <= acc_data;
            assign w_empty = !r_vld;
            assign w_full  = r_vld;
            assign w_head  = r_data;
        end else begin : g_ptr
            logic [AW:0]   r_wp, r_rp;
            logic [DW-1:0] r_mem [ACC_DEPTH];
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    r_wp <= '0;
                    r_rp <= '0;
                end else begin
                    if (w_push) r_wp <= r_wp + 1'b1;
                    if (w_pop) r_rp <= r_rp + 1'b1;
                end
            always_ff @(posedge clk)
                if (w_push) r_mem[r_wp[AW-1:0]] <= acc_data;
            assign w_empty = r_wp == r_rp;
            assign w_full  = (r_wp[AW] != r_rp[AW]) & (r_wp[AW-1:0] == r_rp[AW-1:0]);
            assign w_head  = r_mem[r_rp[AW-1:0]];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            muxreg       <= '0;
            muxreg_valid <= 1'b0;
        end else if (!wb_freeze) begin
            muxreg       <= muxout;
            muxreg_valid <= w_we & !acc_stall;
        end

`ifdef OR1200_WBMUX_STALLCNT_EN
    logic [15:0] r_stall_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_stall_cnt <= '0;
        else if (acc_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    assign acc_stall_cnt = r_stall_cnt;
`else
    assign acc_stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_or1200_wbmux_nch.sv
// tb_or1200_wbmux_nch: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_or1200_wbmux_nch;
    localparam int DW = 32, NSRC = 8, OPW = 4, DEPTH = 2;

    logic          clk = 1'b0, rst = 1'b1, wb_freeze = 1'b0, acc_valid = 1'b0;
    logic [3:0]    rfwb_op = '0;
    logic [255:0]  muxin = '0;
    logic [31:0]   acc_data = '0;
    logic          acc_ready, acc_stall, muxreg_valid;
    logic [31:0]   muxout, muxreg;
    logic [15:0]   acc_stall_cnt;

    int errors = 0, checks = 0;
    logic [31:0] q[$];
    logic [31:0] m_reg = '0;
    logic        m_vld = 1'b0;
    logic [15:0] m_cnt = '0;
    bit          m_taken = 1'b1;

    always #5 clk = ~clk;

    or1200_wbmux_nch #(.DW(DW), .NSRC(NSRC), .OPW(OPW), .ACC_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wb_freeze(wb_freeze), .rfwb_op(rfwb_op), .muxin(muxin),
        .acc_valid(acc_valid), .acc_data(acc_data), .acc_ready(acc_ready), .acc_stall(acc_stall),
        .muxout(muxout), .muxreg(muxreg), .muxreg_valid(muxreg_valid), .acc_stall_cnt(acc_stall_cnt)
    );

    function automatic logic [31:0] exp_mux();
        int s = int'(rfwb_op[3:1]);
        if (s < NSRC - 1) return muxin[s*DW +: DW];
        if (s == NSRC - 1) return q.size() != 0 ? q[0] : (acc_valid ? acc_data : 32'h0);
        return 32'h0;
    endfunction

    function automatic bit exp_stall();
        return rfwb_op[0] && int'(rfwb_op[3:1]) == NSRC - 1 && q.size() == 0 && !acc_valid;
    endfunction

    function automatic logic [15:0] exp_cnt();
`ifdef OR1200_WBMUX_STALLCNT_EN
        return m_cnt;
`else
        return 16'h0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_reg = '0;
        m_vld = 1'b0;
        m_cnt = '0;
        m_taken = 1'b1;
    endtask

    task automatic step();
        logic [31:0] mo;
        bit st, cons, push, emp;
        mo   = exp_mux();
        st   = exp_stall();
        emp  = q.size() == 0;
        cons = !wb_freeze && rfwb_op[0] && int'(rfwb_op[3:1]) == NSRC - 1 && !st;
        push = acc_valid && q.size() < DEPTH && !(emp && cons);
        @(posedge clk);
        if (rst) model_reset();
        else begin
            if (!wb_freeze) begin
                m_reg = mo;
                m_vld = rfwb_op[0] && !st;
            end
            if (cons && !emp) void'(q.pop_front());
            if (push) q.push_back(acc_data);
            if (st && m_cnt != 16'hFFFF) m_cnt++;
            m_taken = push || (cons && emp && acc_valid);
        end
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic frz, input logic av, input logic [31:0] ad);
        rfwb_op = op;
        wb_freeze = frz;
        acc_valid = av;
        acc_data = ad;
        #1;
    endtask

    task automatic test_reset();
        drive(4'b0000, 1'b0, 1'b0, 32'h0);
        step();
        step();
        checks++; if (muxreg !== 32'h0) begin errors++; $display("FAIL reset_muxreg: got %h want 0", muxreg); end
        checks++; if (muxreg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", muxreg_valid); end
        checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", acc_ready); end
        checks++; if (acc_stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", acc_stall_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_mux_select();
        logic [31:0] vals [5] = '{32'h1000_0000, 32'h0100_0000, 32'h0010_0000, 32'h0001_0000, 32'h1001_0000};
        logic [3:0]  ops  [5] = '{4'b0001, 4'b0011, 4'b0101, 4'b0111, 4'b1001};
        for (int i = 0; i < NSRC; i++) muxin[i*DW +: DW] = $urandom;
        for (int i = 0; i < 5; i++) muxin[i*DW +: DW] = vals[i];
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], 1'b0, 1'b0, 32'h0);
            checks++; if (muxout !== vals[i]) begin errors++; $display("FAIL mux_sel%0d: muxout %h want %h", i, muxout, vals[i]); end
            step();
            checks++; if (muxreg !== vals[i] || muxreg_valid !== 1'b1) begin errors++; $display("FAIL mux_reg%0d: muxreg %h/%b want %h/1", i, muxreg, muxreg_valid, vals[i]); end
        end
        drive(4'b1110, 1'b0, 1'b0, 32'h0);
        checks++; if (muxout !== 32'h0) begin errors++; $display("FAIL mux_acc_idle: muxout %h want 0", muxout); end
        step();
        checks++; if (muxreg_valid !== 1'b0 || muxreg !== 32'h0) begin errors++; $display("FAIL mux_acc_noreg: muxreg %h/%b want 0/0", muxreg, muxreg_valid); end
    endtask

    task automatic test_stall_bypass();
        logic [15:0] want_cnt;
`ifdef OR1200_WBMUX_STALLCNT_EN
        want_cnt = 16'd3;
`else
        want_cnt = 16'd0;
`endif
        for (int k = 0; k < 3; k++) begin
            drive(4'b1111, 1'b0, 1'b0, 32'h0);
            checks++; if (acc_stall !== 1'b1) begin errors++; $display("FAIL stall%0d: acc_stall %b want 1", k, acc_stall); end
            step();
            checks++; if (muxreg_valid !== 1'b0) begin errors++; $display("FAIL stall_valid%0d: got %b want 0", k, muxreg_valid); end
        end
        checks++; if (acc_stall_cnt !== want_cnt) begin errors++; $display("FAIL stall_cnt: got %0d want %0d", acc_stall_cnt, want_cnt); end
        drive(4'b1111, 1'b0, 1'b1, 32'h1111_1111);
        checks++; if (acc_stall !== 1'b0 || muxout !== 32'h1111_1111) begin errors++; $display("FAIL bypass: stall %b muxout %h want 0 11111111", acc_stall, muxout); end
        step();
        checks++; if (muxreg !== 32'h1111_1111 || muxreg_valid !== 1'b1) begin errors++; $display("FAIL bypass_reg: %h/%b want 11111111/1", muxreg, muxreg_valid); end
        drive(4'b1111, 1'b0, 1'b0, 32'h0);
        checks++; if (acc_stall !== 1'b1 || acc_ready !== 1'b1) begin errors++; $display("FAIL bypass_empty: stall %b ready %b want 1 1", acc_stall, acc_ready); end
        step();
        drive(4'b0001, 1'b0, 1'b0, 32'h0);
        step();
    endtask

    task automatic test_fifo_full();
        drive(4'b0001, 1'b0, 1'b1, 32'hA0);
        checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL full_ready0: got %b want 1", acc_ready); end
        step();
        drive(4'b0001, 1'b0, 1'b1, 32'hA1);
        step();
        checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL full_ready2: got %b want 0", acc_ready); end
        drive(4'b0001, 1'b0, 1'b1, 32'hA2);
        step();
        checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL full_hold: got %b want 0", acc_ready); end
        drive(4'b1111, 1'b0, 1'b1, 32'hA2);
        checks++; if (muxout !== 32'hA0 || acc_ready !== 1'b0) begin errors++; $display("FAIL full_pop0: muxout %h ready %b want a0 0", muxout, acc_ready); end
        step();
        checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL full_reopen: got %b want 1", acc_ready); end
        checks++; if (muxout !== 32'hA1) begin errors++; $display("FAIL full_pop1: muxout %h want a1", muxout); end
        step();
        drive(4'b1111, 1'b0, 1'b0, 32'h0);
        checks++; if (muxout !== 32'hA2) begin errors++; $display("FAIL full_held: muxout %h want a2", muxout); end
        step();
        drive(4'b0001, 1'b0, 1'b0, 32'h0);
        step();
    endtask

    task automatic test_push_pop();
        drive(4'b0001, 1'b0, 1'b1, 32'hB0);
        step();
        drive(4'b1111, 1'b0, 1'b1, 32'hB1);
        checks++; if (muxout !== 32'hB0) begin errors++; $display("FAIL pp_head: muxout %h want b0", muxout); end
        step();
        checks++; if (acc_ready !== 1'b1 || muxreg !== 32'hB0) begin errors++; $display("FAIL pp_count: ready %b muxreg %h want 1 b0", acc_ready, muxreg); end
        drive(4'b1111, 1'b0, 1'b0, 32'h0);
        checks++; if (muxout !== 32'hB1 || acc_stall !== 1'b0) begin errors++; $display("FAIL pp_next: muxout %h stall %b want b1 0", muxout, acc_stall); end
        step();
        checks++; if (acc_stall !== 1'b1) begin errors++; $display("FAIL pp_drained: stall %b want 1", acc_stall); end
        drive(4'b0001, 1'b0, 1'b0, 32'h0);
        step();
    endtask

    task automatic test_freeze();
        drive(4'b0001, 1'b0, 1'b1, 32'hC0);
        step();
        drive(4'b1111, 1'b1, 1'b1, 32'hC1);
        checks++; if (muxout !== 32'hC0) begin errors++; $display("FAIL frz_head: muxout %h want c0", muxout); end
        step();
        checks++; if (muxreg !== 32'h1000_0000 || muxreg_valid !== 1'b1) begin errors++; $display("FAIL frz_hold: %h/%b want 10000000/1", muxreg, muxreg_valid); end
        checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL frz_push: ready %b want 0", acc_ready); end
        drive(4'b1111, 1'b0, 1'b0, 32'h0);
        checks++; if (muxout !== 32'hC0) begin errors++; $display("FAIL frz_nopop: muxout %h want c0", muxout); end
        step();
        checks++; if (muxreg !== 32'hC0 || muxreg_valid !== 1'b1) begin errors++; $display("FAIL frz_release: %h/%b want c0/1", muxreg, muxreg_valid); end
        checks++; if (muxout !== 32'hC1) begin errors++; $display("FAIL frz_second: muxout %h want c1", muxout); end
        step();
        drive(4'b0001, 1'b0, 1'b0, 32'h0);
        step();
    endtask

    task automatic test_async_reset();
        drive(4'b0001, 1'b0, 1'b1, 32'hD0);
        step();
        drive(4'b0001, 1'b0, 1'b1, 32'hD1);
        step();
        drive(4'b0001, 1'b0, 1'b0, 32'h0);
        checks++; if (acc_ready !== 1'b0 || muxreg !== 32'h1000_0000) begin errors++; $display("FAIL ar_pre: ready %b muxreg %h want 0 10000000", acc_ready, muxreg); end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if (muxreg !== 32'h0 || muxreg_valid !== 1'b0 || acc_ready !== 1'b1 || acc_stall_cnt !== 16'h0) begin
            errors++; $display("FAIL ar_async: muxreg %h valid %b ready %b cnt %h want 0 0 1 0", muxreg, muxreg_valid, acc_ready, acc_stall_cnt);
        end
        rst = 1'b0;
        drive(4'b1111, 1'b0, 1'b0, 32'h0);
        checks++; if (acc_stall !== 1'b1) begin errors++; $display("FAIL ar_empty: stall %b want 1", acc_stall); end
        step();
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic        frz, av;
        logic [31:0] ad;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NSRC; i++) muxin[i*DW +: DW] = $urandom;
            op  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            frz = $urandom_range(0, 4) == 0;
            av  = acc_valid;
            ad  = acc_data;
            if (!(acc_valid && !m_taken)) begin
                av = 1'($urandom_range(0, 1));
                ad = $urandom;
            end
            drive(op, frz, av, ad);
            checks++; if (muxout !== exp_mux()) begin errors++; $display("FAIL rnd_mux%0d: got %h want %h", n, muxout, exp_mux()); end
            checks++; if (acc_stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall%0d: got %b want %b", n, acc_stall, exp_stall()); end
            checks++; if (acc_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready%0d: got %b want %b", n, acc_ready, q.size() < DEPTH); end
            checks++; if (acc_stall_cnt !== exp_cnt()) begin errors++; $display("FAIL rnd_cnt%0d: got %h want %h", n, acc_stall_cnt, exp_cnt()); end
            step();
            checks++; if (muxreg !== m_reg) begin errors++; $display("FAIL rnd_reg%0d: got %h want %h", n, muxreg, m_reg); end
            checks++; if (muxreg_valid !== m_vld) begin errors++; $display("FAIL rnd_valid%0d: got %b want %b", n, muxreg_valid, m_vld); end
        end
    endtask

    initial begin
        test_reset();
        test_mux_select();
        test_stall_bypass();
        test_fifo_full();
        test_push_pop();
        test_freeze();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/or1200_wbmux_nch.md
Name: or1200_wbmux_nch

Overview:
Parametrised N-source write-back multiplexer for the OR1200 pipeline. It generalises the fixed ALU/LSU/SPRS/LR/FPU/keccak write-back mux to NSRC channels of DW bits. The highest channel is reserved for a long-latency accelerator (e.g. keccak). That channel gets a valid/ready result handshake, a small result FIFO and a pipeline stall request. The block sits between the execute-stage result sources and the register-file write port and forwarding network.

Parameters:
DW, 32, data width of every source and output.
NSRC, 8, number of sources; channel NSRC-1 is the accelerator channel (ACC_SEL); must be 2..2^(OPW-1).
OPW, 4, rfwb_op width; bit0 = write enable, bits[OPW-1:1] = source select.
ACC_DEPTH, 2, accelerator result FIFO depth; power of two, minimum 1.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
wb_freeze  in  1  pipeline freeze; holds all registered state except FIFO pushes.
rfwb_op  in  OPW  write-back op; sel = rfwb_op[OPW-1:1], we = rfwb_op[0].
muxin  in  NSRC*DW  flattened sources; channel i = muxin[i*DW +: DW]; the ACC_SEL slice is ignored.
acc_valid  in  1  accelerator result valid.
acc_data  in  DW  accelerator result.
acc_ready  out  1  FIFO can accept; equals !full.
acc_stall  out  1  accelerator result requested but not yet available.
muxout  out  DW  combinational register-file write data (rf_dataw).
muxreg  out  DW  registered forwarding data (wb_forw).
muxreg_valid  out  1  registered forwarding valid (wbforw_valid).
acc_stall_cnt  out  16  accelerator stall-cycle count; see Optional Feature.

Behaviour:
- sel < NSRC-1: muxout = channel sel.
- sel == ACC_SEL:
  - FIFO non-empty: muxout = FIFO head.
  - FIFO empty and acc_valid = 1: muxout = acc_data (bypass).
  - Otherwise: muxout = 0.
- sel >= NSRC: muxout = 0.
- muxout does not depend on we. With we = 0, muxout follows sel as above, but no write and no pop occur.
- acc_stall = we & (sel == ACC_SEL) & fifo_empty & !acc_valid. It is combinational and asserts even during freeze.
- consume = !wb_freeze & we & (sel == ACC_SEL) & !acc_stall.
- push = acc_valid & acc_ready & !(fifo_empty & consume). The bypass case consumes acc_data directly and does not push.
- pop = consume & !fifo_empty.
- Push and pop in the same cycle: count unchanged, head advances, new entry written at the tail.
- Full FIFO: acc_ready = 0; the accelerator holds acc_data/acc_valid stable until ready. A pop while full raises acc_ready in the next cycle, not combinationally.
- Pushes proceed during wb_freeze, so results are never lost while frozen.
- FIFO pointers: log2(ACC_DEPTH)+1 bits wrapping modulo 2*ACC_DEPTH; full/empty derived from MSB compare. For ACC_DEPTH = 1, a single valid flag replaces the pointers.
- Forwarding register, on the rising edge when !wb_freeze:
  - muxreg <= muxout.
  - muxreg_valid <= we & !acc_stall.
- wb_freeze = 1: muxreg and muxreg_valid hold.
- Latency: muxout is 0-cycle; muxreg is 1 cycle.
- Reset (async, immediate): muxreg = 0, muxreg_valid = 0, FIFO empty, acc_ready = 1, acc_stall_cnt = 0. FIFO contents are discarded. acc_stall follows its equation during reset. Reset mid-handshake drops any in-flight result.

Optional Feature:
Macro OR1200_WBMUX_STALLCNT_EN.
- Defined: acc_stall_cnt is a 16-bit saturating counter (sticks at 16'hFFFF). It increments on every clock where acc_stall = 1 and clears only on rst.
- Undefined: no counter is synthesised and acc_stall_cnt is tied to 16'h0000.

Test Plan:
1. Mux select, defaults: load channels 0..4 = 32'h1000_0000, 32'h0100_0000, 32'h0010_0000, 32'h0001_0000, 32'h1001_0000. Apply rfwb_op = 4'b0001, 0011, 0101, 0111, 1001 -> muxout equals each value in the same cycle; muxreg matches one edge later with muxreg_valid = 1. rfwb_op = 4'b1110 -> muxout = channel 7 path (0 with FIFO empty and acc_valid = 0), muxreg_valid = 0 next edge.
2. Accelerator stall then bypass: rfwb_op = 4'b1111 with FIFO empty and acc_valid = 0 for 3 cycles -> acc_stall = 1, muxreg_valid = 0. Then acc_valid = 1 with acc_data = 32'h1111_1111 -> acc_stall = 0, muxout = 32'h1111_1111, FIFO stays empty, muxreg = 32'h1111_1111 next edge. With the macro defined, acc_stall_cnt = 3.
3. FIFO fill/full: with rfwb_op = 4'b0001, push 32'hA0, then 32'hA1 -> acc_ready = 0 after the second push. A third acc_valid is held off. Then rfwb_op = 4'b1111 for 2 cycles -> muxout = 32'hA0 then 32'hA1. acc_ready = 1 again one cycle after the first pop; the held third value is accepted.
4. Simultaneous push/pop: FIFO holds 1 entry (32'hB0); rfwb_op = 4'b1111 and acc_valid = 1 with 32'hB1 in the same cycle -> muxout = 32'hB0, count stays 1, next head = 32'hB1.
5. Freeze: wb_freeze = 1, rfwb_op = 4'b1111, FIFO = {32'hC0}, acc_valid with 32'hC1 -> no pop, push accepted (count 2), muxreg/muxreg_valid unchanged. Release freeze -> 32'hC0 popped.
6. Async reset mid-operation: FIFO holds 2 entries and muxreg = 32'h1000_0000. Assert rst between clock edges -> immediately muxreg = 0, muxreg_valid = 0, acc_ready = 1. After release, rfwb_op = 4'b1111 with acc_valid = 0 -> acc_stall = 1 (FIFO empty).
